// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared definitions for the fetch/data memory arbiter.
//   arbstate_t     : arbiter FSM encoding (IDLE, GRANT, RESP)
//   OWNER_I/D      : owner encodings (0 = instruction fetch, 1 = data)
//   TIMEOUT_RESULT : read data returned to the owner when an access times out
//   OPLEN_WORD     : operand length used for every instruction fetch
//   pick_winner    : round-robin winner select between the two requesters
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } arbstate_t;

   localparam logic        OWNER_I        = 1'b0;
   localparam logic        OWNER_D        = 1'b1;
   localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;
   localparam logic [1:0]  OPLEN_WORD     = 2'b10;

   // A lone requester always wins; under contention the side that was not
   // served last wins, so continuous dual traffic alternates.
   function automatic logic pick_winner(input logic i_req,
                                        input logic d_req,
                                        input logic last_owner);
      logic w;
      if (i_req && d_req) w = ~last_owner;
      else if (d_req)     w = OWNER_D;
      else                w = OWNER_I;
      return w;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates an instruction-fetch port and a data port onto a
// single shared memory controller, one access outstanding at a time.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_enable, i_addr            : fetch request (held until i_valid)
//   i_valid, i_result           : fetch completion pulse / read data
//   d_enable, d_addr, d_wdata,
//   d_we, d_oplen, d_unsigned   : data request (held until d_valid)
//   d_valid, d_result           : data completion pulse / load data
//   m_enable, m_addr, m_wdata,
//   m_we, m_oplen, m_unsigned   : registered request to the memory controller
//   m_valid, m_result           : memory controller completion
//   busy, owner, err            : FSM not idle / current owner / sticky timeout
//
// Configuration
//   ARB_TIMEOUT_EN : when defined, a granted access that sees no m_valid for
//                    TIMEOUT_CYCLES cycles is completed with TIMEOUT_RESULT
//                    and err is set until reset. When undefined, GRANT waits
//                    indefinitely and err is tied low.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_enable,
   input  logic [31:0] i_addr,
   output logic        i_valid,
   output logic [31:0] i_result,
   input  logic        d_enable,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_we,
   input  logic [1:0]  d_oplen,
   input  logic        d_unsigned,
   output logic        d_valid,
   output logic [31:0] d_result,
   output logic        m_enable,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_we,
   output logic [1:0]  m_oplen,
   output logic        m_unsigned,
   input  logic        m_valid,
   input  logic [31:0] m_result,
   output logic        busy,
   output logic        owner,
   output logic        err
);

   if (TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   arbstate_t state, next_state;
   logic      last_owner;
   logic      req_any;
   logic      winner;
   logic      done_ok;
   logic      timed_out;
   logic      finish;
   logic      start;

   assign req_any = i_enable | d_enable;
   assign winner  = pick_winner(i_enable, d_enable, last_owner);
   assign start   = (state == IDLE) && req_any;
   // m_valid only counts while an access is granted; IDLE/RESP ignore it.
   assign done_ok = (state == GRANT) && m_valid;
   assign finish  = done_ok | timed_out;
   assign busy    = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;

   // wait_cnt holds the number of GRANT cycles already completed, so the
   // access is abandoned at the end of GRANT cycle number TIMEOUT_CYCLES.
   assign timed_out = (state == GRANT) && !m_valid && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (start)
            wait_cnt <= '0;
         else if (state == GRANT)
            wait_cnt <= wait_cnt + 1'b1;
         if (timed_out)
            err <= 1'b1;
      end
   end
`else
   assign timed_out = 1'b0;
   assign err       = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_any) next_state = GRANT;
         GRANT:   if (finish)  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request/response datapath. The m_* fields are registered at grant and
   // left untouched for the whole GRANT phase, so requesters may drop or
   // change their inputs without disturbing the access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_enable   <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_we       <= 1'b0;
         m_oplen    <= '0;
         m_unsigned <= 1'b0;
         owner      <= OWNER_I;
         last_owner <= OWNER_I;
         i_valid    <= 1'b0;
         d_valid    <= 1'b0;
         i_result   <= '0;
         d_result   <= '0;
      end else begin
         i_valid <= 1'b0;
         d_valid <= 1'b0;

         if (start) begin
            m_enable   <= 1'b1;
            owner      <= winner;
            last_owner <= winner;
            if (winner == OWNER_D) begin
               m_addr     <= d_addr;
               m_wdata    <= d_wdata;
               m_we       <= d_we;
               m_oplen    <= d_oplen;
               m_unsigned <= d_unsigned;
            end else begin
               m_addr     <= i_addr;
               m_wdata    <= '0;
               m_we       <= 1'b0;
               m_oplen    <= OPLEN_WORD;
               m_unsigned <= 1'b0;
            end
         end

         if (finish) begin
            // Quiet the controller bus between accesses.
            m_enable   <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_we       <= 1'b0;
            m_oplen    <= '0;
            m_unsigned <= 1'b0;
            if (owner == OWNER_D) begin
               d_valid  <= 1'b1;
               d_result <= done_ok ? m_result : TIMEOUT_RESULT;
            end else begin
               i_valid  <= 1'b1;
               i_result <= done_ok ? m_result : TIMEOUT_RESULT;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed, self-checking bench for mem_arbiter.
// Expected completions are queued when m_valid is driven and compared when
// the arbiter pulses i_valid/d_valid. Timeout behaviour is exercised when
// ARB_TIMEOUT_EN is defined; otherwise the indefinite wait is exercised.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        i_enable;
   logic [31:0] i_addr;
   logic        i_valid;
   logic [31:0] i_result;
   logic        d_enable;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_we;
   logic [1:0]  d_oplen;
   logic        d_unsigned;
   logic        d_valid;
   logic [31:0] d_result;
   logic        m_enable;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_we;
   logic [1:0]  m_oplen;
   logic        m_unsigned;
   logic        m_valid;
   logic [31:0] m_result;
   logic        busy;
   logic        owner;
   logic        err;

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_enable(i_enable), .i_addr(i_addr), .i_valid(i_valid), .i_result(i_result),
      .d_enable(d_enable), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
      .d_oplen(d_oplen), .d_unsigned(d_unsigned), .d_valid(d_valid), .d_result(d_result),
      .m_enable(m_enable), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
      .m_oplen(m_oplen), .m_unsigned(m_unsigned), .m_valid(m_valid), .m_result(m_result),
      .busy(busy), .owner(owner), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        own;
      logic [31:0] res;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_i;
   logic [31:0] last_d;
   int          errors;
   int          checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {31'h0, obs}, {31'h0, exp});
   endtask

   // Advance one cycle and inspect outputs 1 time unit after the edge; any
   // completion pulse is matched against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (i_valid || d_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", {30'h0, i_valid, d_valid}, 32'h0);
         end else begin
            e = sb.pop_front();
            chk1("valid_exclusive", i_valid & d_valid, 1'b0);
            chk1("i_valid_owner", i_valid, e.own == OWNER_I);
            chk1("d_valid_owner", d_valid, e.own == OWNER_D);
            if (e.own == OWNER_D) begin
               chk("d_result", d_result, e.res);
               chk("i_result_hold", i_result, last_i);
               last_d = e.res;
            end else begin
               chk("i_result", i_result, e.res);
               chk("d_result_hold", d_result, last_d);
               last_i = e.res;
            end
         end
      end
   endtask

   task automatic wait_grant();
      int n = 0;
      while (!m_enable && n < 20) begin
         tick();
         n++;
      end
      chk1("grant_seen", m_enable, 1'b1);
   endtask

   task automatic complete(input logic [31:0] r, input logic own);
      exp_t e;
      e.own = own;
      e.res = r;
      m_valid  = 1'b1;
      m_result = r;
      sb.push_back(e);
      tick();
      m_valid = 1'b0;
      chk("completion_seen", 32'(sb.size()), 32'h0);
      chk1("m_enable_dropped", m_enable, 1'b0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      sb.delete();
      last_i = '0;
      last_d = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic exp_own;
      int   ncyc;
      errors = 0;
      checks = 0;
      last_i = '0;
      last_d = '0;
      rst_n = 1'b0;
      i_enable = 0; i_addr = '0;
      d_enable = 0; d_addr = '0; d_wdata = '0; d_we = 0; d_oplen = '0; d_unsigned = 0;
      m_valid = 0; m_result = '0;

      // Reset state
      tick();
      tick();
      chk1("rst_m_enable", m_enable, 1'b0);
      chk("rst_m_addr", m_addr, 32'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_i_valid", i_valid, 1'b0);
      chk1("rst_d_valid", d_valid, 1'b0);
      chk("rst_i_result", i_result, 32'h0);
      chk("rst_d_result", d_result, 32'h0);
      rst_n = 1'b1;
      tick();

      // m_valid while idle is ignored
      m_valid = 1'b1; m_result = 32'h0000_0055;
      tick();
      tick();
      m_valid = 1'b0;
      chk1("idle_mvalid_busy", busy, 1'b0);
      chk("idle_mvalid_i_result", i_result, 32'h0);

      // Fetch only
      i_enable = 1'b1; i_addr = 32'h0000_0010;
      wait_grant();
      chk("f_m_addr", m_addr, 32'h0000_0010);
      chk1("f_m_we", m_we, 1'b0);
      chk("f_m_oplen", {30'h0, m_oplen}, 32'h2);
      chk1("f_m_unsigned", m_unsigned, 1'b0);
      chk("f_m_wdata", m_wdata, 32'h0);
      chk1("f_owner", owner, OWNER_I);
      chk1("f_busy", busy, 1'b1);
      tick();
      tick();
      chk1("f_hold_enable", m_enable, 1'b1);
      complete(32'h0000_0013, OWNER_I);
      i_enable = 1'b0;
      tick();
      chk1("f_pulse_one_cycle", i_valid, 1'b0);
      chk1("f_busy_after", busy, 1'b0);

      // Data store, fields held stable until m_valid
      d_enable = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
      d_we = 1'b1; d_oplen = 2'b10; d_unsigned = 1'b0;
      wait_grant();
      chk1("s_owner", owner, OWNER_D);
      for (int k = 0; k < 3; k++) begin
         chk("s_m_addr", m_addr, 32'h0000_0100);
         chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
         chk1("s_m_we", m_we, 1'b1);
         chk("s_m_oplen", {30'h0, m_oplen}, 32'h2);
         chk1("s_m_enable", m_enable, 1'b1);
         tick();
      end
      complete(32'h1234_5678, OWNER_D);
      d_enable = 1'b0;
      tick();

      // Round robin from reset: D, I, D, I with both requests held
      apply_reset();
      chk("rr_rst_i_result", i_result, 32'h0);
      chk("rr_rst_d_result", d_result, 32'h0);
      i_enable = 1'b1; i_addr = 32'h0000_0400;
      d_enable = 1'b1; d_addr = 32'h0000_0800; d_wdata = 32'h1111_2222;
      d_we = 1'b1; d_oplen = 2'b00; d_unsigned = 1'b1;
      exp_own = OWNER_D;
      for (int k = 0; k < 4; k++) begin
         wait_grant();
         chk1("rr_owner", owner, exp_own);
         if (exp_own == OWNER_D) begin
            chk("rr_d_addr", m_addr, 32'h0000_0800);
            chk1("rr_d_unsigned", m_unsigned, 1'b1);
         end else begin
            chk("rr_i_addr", m_addr, 32'h0000_0400);
            chk1("rr_i_we", m_we, 1'b0);
            chk("rr_i_wdata", m_wdata, 32'h0);
            chk("rr_i_oplen", {30'h0, m_oplen}, 32'h2);
            chk1("rr_i_unsigned", m_unsigned, 1'b0);
         end
         complete(32'hA000_0000 + 32'(k), exp_own);
         exp_own = ~exp_own;
      end
      i_enable = 1'b0;
      d_enable = 1'b0;
      tick();
      tick();

      // Owner drops enable mid-GRANT; access still completes
      i_enable = 1'b1; i_addr = 32'h0000_0020;
      wait_grant();
      i_enable = 1'b0;
      tick();
      tick();
      chk1("drop_hold_enable", m_enable, 1'b1);
      complete(32'h0000_CAFE, OWNER_I);
      tick();
      tick();
      tick();
      chk1("drop_idle_after", busy, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // Timeout after 8 GRANT cycles
      begin
         exp_t e;
         e.own = OWNER_I;
         e.res = TIMEOUT_RESULT;
         i_enable = 1'b1; i_addr = 32'h0000_0030;
         wait_grant();
         sb.push_back(e);
         ncyc = 1;
         while (m_enable && ncyc < 40) begin
            tick();
            if (m_enable) ncyc++;
         end
         i_enable = 1'b0;
         chk("to_grant_cycles", 32'(ncyc), 32'd8);
         chk("to_completion_seen", 32'(sb.size()), 32'h0);
         chk1("to_err", err, 1'b1);
         tick();
         tick();
         tick();
         chk1("to_err_sticky", err, 1'b1);
         apply_reset();
         chk1("to_err_cleared", err, 1'b0);
      end
`else
      // Without the timeout the grant waits indefinitely
      i_enable = 1'b1; i_addr = 32'h0000_0030;
      wait_grant();
      repeat (20) tick();
      chk1("nto_still_granted", m_enable, 1'b1);
      chk1("nto_err", err, 1'b0);
      complete(32'h0000_0077, OWNER_I);
      i_enable = 1'b0;
      tick();
`endif

      // Reset mid-GRANT aborts asynchronously, then a load is served normally
      d_enable = 1'b1; d_addr = 32'h0000_0300; d_we = 1'b1; d_wdata = 32'h5555_AAAA;
      wait_grant();
      #2;
      rst_n = 1'b0;
      #1;
      chk1("arst_m_enable", m_enable, 1'b0);
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_owner", owner, 1'b0);
      d_enable = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      last_i = '0;
      last_d = '0;
      tick();
      chk1("arst_no_pulse", d_valid, 1'b0);
      d_enable = 1'b1; d_addr = 32'h0000_0200; d_we = 1'b0; d_wdata = '0;
      d_oplen = 2'b01; d_unsigned = 1'b1;
      wait_grant();
      chk("ld_m_addr", m_addr, 32'h0000_0200);
      chk("ld_m_oplen", {30'h0, m_oplen}, 32'h1);
      chk1("ld_m_unsigned", m_unsigned, 1'b1);
      chk1("ld_m_we", m_we, 1'b0);
      tick();
      complete(32'h0000_00AB, OWNER_D);
      d_enable = 1'b0;
      tick();
      tick();
      chk("end_sb_empty", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
